keypad_scan: RTL and testbench

//  4x4 matrix keypad scanner, upstream of the safe's main control FSM.
//  - Drives columns, samples rows, debounces, encodes the key.
//  - Outputs key_value plus a level key_valid; the consumer detects its rising edge.
//  - Runs entirely on clk (50 MHz) with an internal scan tick. No second clock domain.

---
 rtl/keypad_scan_pkg.sv | 71 +++++++
 rtl/keypad_scan_if.sv | 24 ++
 rtl/keypad_tick_gen.sv | 26 ++
 rtl/keypad_scan.sv | 195 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_pkg.sv
// Shared keypad definitions: key codes, scanner FSM states and encoding helpers.
// Imported by the scanner and available to the main control logic.
package keypad_scan_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hD;
  localparam logic [3:0] KEY_D    = 4'hE;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Row-major key map: {row, col}, bit 0 of each field is index 0.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_0;
    case ({row, col})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_A;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic one_low(input logic [3:0] rows);
    return (rows == 4'b1110) || (rows == 4'b1101) ||
           (rows == 4'b1011) || (rows == 4'b0111);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    case (rows)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the key report seen by the main control FSM.
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_value;
  logic       key_valid;
  logic       scan_busy;

  modport master (
    input  row_in,
    output col_out,
    output key_value,
    output key_valid,
    output scan_busy
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_value,
    input  key_valid,
    input  scan_busy
  );
endinterface

// File: rtl/keypad_tick_gen.sv
// Scan tick divider: one-clk pulse every SCAN_DIV clk cycles.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, debounce FSM, key encoder.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_PERIOD  = 100
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp
);

  // One extra count of headroom so cnt_q + 1 never wraps before the compare.
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_TICKS + 2);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);

  logic tick;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  logic [3:0]       sync_q, row_s_q;
  kp_state_e        state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_lat_q, row_lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_value_q, key_value_d;
  logic             key_valid_q, key_valid_d;
  logic             row_match, row_up;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned PER_W  = $clog2(REPEAT_PERIOD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [PER_W-1:0]  per_q, per_d, per_inc;

  assign hold_inc = hold_q + 1'b1;
  assign per_inc  = per_q + 1'b1;
`endif

  assign cnt_inc   = cnt_q + 1'b1;
  assign row_match = (row_s_q == ~(4'b0001 << row_lat_q));
  assign row_up    = row_s_q[row_lat_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 4'hF;
      row_s_q <= 4'hF;
    end else begin
      sync_q  <= kp.row_in;
      row_s_q <= sync_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_lat_d   = row_lat_q;
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    key_valid_d = key_valid_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_d      = hold_q;
    per_d       = per_q;
`endif
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          // Ghosted/multi-key patterns are treated like no key: keep rotating.
          if (one_low(row_s_q)) begin
            row_lat_d = low_index(row_s_q);
            cnt_d     = CNT_W'(1);
            if (DEBOUNCE_TICKS <= 1) begin
              key_value_d = key_code(low_index(row_s_q), col_q);
              key_valid_d = 1'b1;
              state_d     = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_match) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_DONE) begin
              key_value_d = key_code(row_lat_q, col_q);
              key_valid_d = 1'b1;
              state_d     = ST_PRESSED;
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (row_up) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE_TICKS <= 1) begin
              key_valid_d = 1'b0;
              state_d     = ST_SCAN;
              col_d       = col_q + 2'd1;
            end else begin
              state_d = ST_RELEASE;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_d = '0;
            per_d  = '0;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else begin
            // A repeat drops key_valid for exactly one tick; restore it on the next.
            if (!key_valid_q) key_valid_d = 1'b1;
            if (hold_q < HOLD_W'(REPEAT_DELAY)) begin
              hold_d = hold_inc;
              if (hold_inc == HOLD_W'(REPEAT_DELAY)) begin
                key_valid_d = 1'b0;
                per_d       = '0;
              end
            end else begin
              per_d = per_inc;
              if (per_inc == PER_W'(REPEAT_PERIOD)) begin
                key_valid_d = 1'b0;
                per_d       = '0;
              end
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (row_up) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_DONE) begin
              key_valid_d = 1'b0;
              state_d     = ST_SCAN;
              col_d       = col_q + 2'd1;
            end
          end else begin
            state_d     = ST_PRESSED;
            key_valid_d = 1'b1;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      row_lat_q   <= 2'd0;
      cnt_q       <= '0;
      key_value_q <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_lat_q   <= row_lat_d;
      cnt_q       <= cnt_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      per_q  <= '0;
    end else begin
      hold_q <= hold_d;
      per_q  <= per_d;
    end
  end
`endif

  assign kp.col_out   = ~(4'b0001 << col_q);
  assign kp.key_value = key_value_q;
  assign kp.key_valid = key_valid_q;
  assign kp.scan_busy = (state_q != ST_SCAN);

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: behavioural keypad with bounce, latency/edge checks against the key map.
// Auto-repeat checks are compiled in when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DT = 3;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int PRESS_MAX = (4 + DT) * SD + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_TICKS (DT)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  // Physical keypad: key index = row*4 + col; a held key pulls its row low when its column is driven.
  logic [15:0] pressed = '0;
  logic [3:0]  rows_model;
  always_comb begin
    rows_model = 4'hF;
    for (int r = 0; r < 4; r++) rows_model[r] = ~(|(pressed[r*4 +: 4] & ~kp.col_out));
  end
  assign kp.row_in = rows_model;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          rise_cnt = 0, fall_cnt = 0, busy_cnt = 0, col_chg = 0;
  int unsigned last_rise_cyc = 0, last_fall_cyc = 0;
  logic [3:0]  last_rise_val = 4'h0;
  logic        kv_prev = 1'b0;
  logic [3:0]  col_prev = 4'b1110;
  int unsigned rise_log[$];
  int unsigned fall_log[$];

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1 && kv_prev === 1'b0) begin
      rise_cnt      <= rise_cnt + 1;
      last_rise_cyc <= cyc;
      last_rise_val <= kp.key_value;
      rise_log.push_back(cyc);
    end
    if (kp.key_valid === 1'b0 && kv_prev === 1'b1) begin
      fall_cnt      <= fall_cnt + 1;
      last_fall_cyc <= cyc;
      fall_log.push_back(cyc);
    end
    if (kp.scan_busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (kp.col_out !== col_prev) col_chg <= col_chg + 1;
    kv_prev  <= kp.key_valid;
    col_prev <= kp.col_out;
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] ref_code(input int k);
    string m;
    byte   ch;
    m  = "123A456B789C*0#D";
    ch = m[k];
    case (ch)
      "A":     return 4'hA;
      "B":     return 4'hB;
      "C":     return 4'hD;
      "D":     return 4'hE;
      "*":     return 4'hC;
      "#":     return 4'hF;
      default: return 4'(ch - 8'd48);
    endcase
  endfunction

  task automatic press_release(input int k, input int bnc, input int hold, input int rbnc,
                               output int nr, output int lat, output logic [3:0] val,
                               output int flat);
    int r0, f0;
    int unsigned t0, t1;
    r0 = rise_cnt;
    for (int i = 0; i < bnc; i++) begin
      pressed[k] = 1'b1; repeat (SD) @(negedge clk);
      pressed[k] = 1'b0; repeat (SD) @(negedge clk);
    end
    pressed[k] = 1'b1;
    t0 = cyc;
    while (rise_cnt == r0 && (cyc - t0) < 60) @(negedge clk);
    if (rise_cnt != r0) begin
      lat = int'(last_rise_cyc - t0);
      val = last_rise_val;
    end else begin
      lat = -1;
      val = 4'hx;
    end
    repeat (hold * SD) @(negedge clk);
    for (int i = 0; i < rbnc; i++) begin
      pressed[k] = 1'b0; repeat (SD) @(negedge clk);
      pressed[k] = 1'b1; repeat (SD) @(negedge clk);
    end
    f0 = fall_cnt;
    pressed[k] = 1'b0;
    t1 = cyc;
    while (fall_cnt == f0 && (cyc - t1) < 60) @(negedge clk);
    flat = (fall_cnt != f0) ? int'(last_fall_cyc - t1) : -1;
    repeat (3 * SD) @(negedge clk);
    nr = rise_cnt - r0;
  endtask

  task automatic test_reset();
    logic [3:0]  prev;
    int unsigned tprev, t0;
    int          r0;
    rst_n = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    total++; if (kp.col_out !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", kp.col_out); end
    total++; if (kp.key_value !== 4'h0) begin bad++; $display("FAIL reset_value got=%h exp=0", kp.key_value); end
    total++; if (kp.key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", kp.key_valid); end
    total++; if (kp.scan_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", kp.scan_busy); end
    r0 = rise_cnt;
    rst_n = 1'b1;
    prev  = kp.col_out;
    tprev = cyc;
    for (int n = 0; n < 8; n++) begin
      t0 = cyc;
      while (kp.col_out === prev && (cyc - t0) < 20) @(negedge clk);
      total++;
      if (kp.col_out !== {prev[2:0], prev[3]}) begin
        bad++; $display("FAIL scan_rotate step=%0d got=%b exp=%b", n, kp.col_out, {prev[2:0], prev[3]});
      end
      if (n > 0) begin
        total++;
        if (cyc - tprev != SD) begin bad++; $display("FAIL scan_period step=%0d got=%0d exp=%0d", n, cyc - tprev, SD); end
      end
      prev  = kp.col_out;
      tprev = cyc;
    end
    total++; if (rise_cnt != r0) begin bad++; $display("FAIL idle_valid rises=%0d exp=0", rise_cnt - r0); end
  endtask

  task automatic test_clean_press();
    int nr, lat, flat;
    logic [3:0] val;
    press_release(6, 0, 4, 0, nr, lat, val, flat);
    total++; if (nr != 1) begin bad++; $display("FAIL clean_rises got=%0d exp=1", nr); end
    total++; if (val !== ref_code(6)) begin bad++; $display("FAIL clean_value got=%h exp=%h", val, ref_code(6)); end
    total++; if (lat < 8 || lat > PRESS_MAX) begin bad++; $display("FAIL clean_latency got=%0d exp=8..%0d", lat, PRESS_MAX); end
    total++; if (flat < 8 || flat > 16) begin bad++; $display("FAIL clean_release got=%0d exp=8..16", flat); end
  endtask

  task automatic test_bounce();
    int nr, lat, flat;
    logic [3:0] val;
    press_release(11, 2, 4, 2, nr, lat, val, flat);
    total++; if (nr != 1) begin bad++; $display("FAIL bounce_rises got=%0d exp=1", nr); end
    total++; if (val !== 4'hD) begin bad++; $display("FAIL bounce_value got=%h exp=d", val); end
    total++; if (lat < 8 || lat > PRESS_MAX) begin bad++; $display("FAIL bounce_latency got=%0d exp=8..%0d", lat, PRESS_MAX); end
    total++; if (flat < 8 || flat > 16) begin bad++; $display("FAIL bounce_release got=%0d exp=8..16", flat); end
  endtask

  task automatic test_ghost();
    int r0, b0, c0;
    r0 = rise_cnt; b0 = busy_cnt; c0 = col_chg;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    repeat (20 * SD) @(negedge clk);
    pressed = '0;
    repeat (2 * SD) @(negedge clk);
    total++; if (rise_cnt != r0) begin bad++; $display("FAIL ghost_valid rises=%0d exp=0", rise_cnt - r0); end
    total++; if (busy_cnt != b0) begin bad++; $display("FAIL ghost_busy cycles=%0d exp=0", busy_cnt - b0); end
    total++; if (col_chg - c0 < 18) begin bad++; $display("FAIL ghost_scan changes=%0d exp>=18", col_chg - c0); end
  endtask

  task automatic test_reset_midpress();
    int r0, f0;
    int unsigned t0;
    r0 = rise_cnt;
    pressed[14] = 1'b1;
    t0 = cyc;
    while (rise_cnt == r0 && (cyc - t0) < 60) @(negedge clk);
    total++; if (rise_cnt == r0) begin bad++; $display("FAIL midrst_first_rise got=none exp=rise"); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({kp.col_out, kp.key_value, kp.key_valid, kp.scan_busy} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midrst_outputs got=%b/%h/%b/%b exp=1110/0/0/0",
                      kp.col_out, kp.key_value, kp.key_valid, kp.scan_busy);
    end
    repeat (3) @(negedge clk);
    r0 = rise_cnt;
    rst_n = 1'b1;
    t0 = cyc;
    while (rise_cnt == r0 && (cyc - t0) < 60) @(negedge clk);
    total++; if (rise_cnt == r0) begin bad++; $display("FAIL midrst_rerise got=none exp=rise"); end
    total++; if (last_rise_val !== 4'hF) begin bad++; $display("FAIL midrst_value got=%h exp=f", last_rise_val); end
    total++;
    if (int'(last_rise_cyc - t0) > PRESS_MAX) begin
      bad++; $display("FAIL midrst_latency got=%0d exp<=%0d", int'(last_rise_cyc - t0), PRESS_MAX);
    end
    f0 = fall_cnt;
    pressed[14] = 1'b0;
    t0 = cyc;
    while (fall_cnt == f0 && (cyc - t0) < 60) @(negedge clk);
    repeat (3 * SD) @(negedge clk);
  endtask

  task automatic test_hold();
    int r0, nf0, nr0, vbad, f0;
    int unsigned base, t0;
    int unsigned fw[$];
    int unsigned rw[$];
    r0 = rise_cnt; nf0 = fall_log.size(); nr0 = rise_log.size();
    pressed[3] = 1'b1;
    t0 = cyc;
    while (rise_cnt == r0 && (cyc - t0) < 60) @(negedge clk);
    total++; if (rise_cnt == r0) begin bad++; $display("FAIL hold_rise got=none exp=rise"); end
    base = last_rise_cyc;
    vbad = 0;
    while (cyc < base + 78) begin
      if (kp.key_value !== 4'hA) vbad++;
      @(negedge clk);
    end
    for (int i = nf0; i < fall_log.size(); i++)
      if (fall_log[i] > base && fall_log[i] <= base + 78) fw.push_back(fall_log[i] - base);
    for (int i = nr0; i < rise_log.size(); i++)
      if (rise_log[i] > base && rise_log[i] <= base + 78) rw.push_back(rise_log[i] - base);
    total++; if (vbad != 0) begin bad++; $display("FAIL hold_value wrong_samples=%0d exp=0 (value a)", vbad); end
`ifdef KEYPAD_AUTOREPEAT_EN
    total++;
    if (fw.size() != 3 || rw.size() != 3) begin
      bad++; $display("FAIL repeat_count falls=%0d rises=%0d exp=3/3", fw.size(), rw.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (fw[i] != RD * SD + i * RP * SD || rw[i] != fw[i] + SD) begin
          bad++; $display("FAIL repeat_edge n=%0d fall=%0d rise=%0d exp=%0d/%0d",
                          i, fw[i], rw[i], RD * SD + i * RP * SD, RD * SD + i * RP * SD + SD);
        end
      end
    end
`else
    total++;
    if (fw.size() != 0 || rw.size() != 0) begin
      bad++; $display("FAIL hold_single_pulse falls=%0d rises=%0d exp=0/0", fw.size(), rw.size());
    end
`endif
    f0 = fall_cnt;
    pressed[3] = 1'b0;
    t0 = cyc;
    while (fall_cnt == f0 && (cyc - t0) < 60) @(negedge clk);
    total++; if (fall_cnt == f0) begin bad++; $display("FAIL hold_release got=none exp=fall"); end
    repeat (3 * SD) @(negedge clk);
  endtask

  task automatic test_random();
    int k, bnc, rbnc, hold, nr, lat, flat;
    logic [3:0] val;
    for (int it = 0; it < 8; it++) begin
      k    = int'($urandom_range(0, 15));
      bnc  = int'($urandom_range(0, 2));
      rbnc = int'($urandom_range(0, 2));
      hold = int'($urandom_range(3, 6));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      press_release(k, bnc, hold, rbnc, nr, lat, val, flat);
      total++;
      if (nr != 1 || val !== ref_code(k)) begin
        bad++; $display("FAIL rand_key it=%0d key=%0d rises=%0d value=%h exp=1/%h", it, k, nr, val, ref_code(k));
      end
      total++;
      if (lat < 8 || lat > PRESS_MAX || flat < 8 || flat > 16) begin
        bad++; $display("FAIL rand_timing it=%0d key=%0d press=%0d release=%0d exp=8..%0d/8..16",
                        it, k, lat, flat, PRESS_MAX);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghost();
    test_reset_midpress();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
